power_sequencer: RTL and testbench
==================================

POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 Parameter NUM_DOMAINS, default 2, number of independently gated HF clock domains.
REQ-002 Parameter DATA_WIDTH, default 32, width of the monitored register bus.
REQ-003 Parameter IDLE_CYCLES, default 16, consecutive idle cycles before a domain powers down; legal range >= 1.
REQ-004 Parameter WARMUP_CYCLES, default 4, cycles with powerup high before enable; legal range >= 1.
REQ-005 Parameter TRIGGER_VALUE, default 32'h1000, rdsp value that counts toward arming sleep.
REQ-006 Parameter TRIGGER_COUNT, default 2, trigger hits required to arm sleep; legal range >= 1.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 fast_clk  in  1  sole clock, all state on rising edge.
REQ-009 reset  in  1  asynchronous active-high reset.
REQ-010 rdsp  in  DATA_WIDTH  monitored register value.
REQ-011 wake_req  in  NUM_DOMAINS  per-domain wake request, level.
REQ-012 busy  in  NUM_DOMAINS  per-domain activity indication, level.
REQ-013 clkhf_enable  out  NUM_DOMAINS  per-domain oscillator enable.
REQ-014 clkhf_powerup  out  NUM_DOMAINS  per-domain oscillator powerup.
REQ-015 domain_ready  out  NUM_DOMAINS  high only in state ON.
REQ-016 sleep_armed  out  1  high once power-down is permitted.

Function
REQ-017 Each domain SHALL run one FSM: ON, DRAIN, OFF, WARMUP; outputs registered, decoded from state.
REQ-018 Outputs per state SHALL be: ON enable=1 powerup=1 ready=1; DRAIN 0/1/0; OFF 0/0/0; WARMUP 0/1/0.
REQ-019 In ON, the idle counter SHALL increment each cycle with busy=0, wake_req=0 and sleep_armed=1, and clear to 0 otherwise.
REQ-020 ON -> DRAIN SHALL occur on the edge where the idle counter equals IDLE_CYCLES-1 and increments; busy or wake_req in that cycle wins (stay ON, counter cleared).
REQ-021 DRAIN SHALL last exactly one cycle, then go to OFF, or to WARMUP if wake_req=1 in that cycle.
REQ-022 OFF -> WARMUP on wake_req=1; busy in OFF SHALL be ignored.
REQ-023 WARMUP SHALL last exactly WARMUP_CYCLES cycles, then go to ON with idle counter 0; wake_req in WARMUP neither restarts nor extends it.
REQ-024 Wake latency: wake_req sampled high in OFF at edge t SHALL give domain_ready=1 after edge t+WARMUP_CYCLES.
REQ-025 Trigger counter SHALL increment on every edge with rdsp==TRIGGER_VALUE, saturate at TRIGGER_COUNT, never decrement; sleep_armed=1 when saturated, sticky until reset.
REQ-026 Counter widths SHALL be $clog2(max+1) of their terminal values; no wrap-around permitted.
REQ-027 Domains SHALL be fully independent except for the shared sleep_armed.

Reset
REQ-028 Reset SHALL force every domain to ON (enable=1, powerup=1, ready=1), all idle/warmup counters 0, trigger counter 0, sleep_armed=0 (1 when the trigger feature is compiled out).
REQ-029 Reset asserted mid-DRAIN, OFF or WARMUP SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro PMU_RDSP_TRIGGER_EN: defined -> REQ-025 trigger logic present; undefined -> no trigger counter, rdsp unused, sleep_armed constant 1.

Structure
REQ-031 Package pmu_pkg SHALL hold the domain state enum (ON, DRAIN, OFF, WARMUP) and the per-state output encoding constants.
REQ-032 Sub-module pmu_domain_fsm SHALL implement one domain (REQ-017..REQ-023) and be instantiated NUM_DOMAINS times by generate.

Verification
REQ-033 Reset release, busy=0, rdsp=0, trigger enabled -> all domains stay ON indefinitely, sleep_armed=0.
REQ-034 rdsp=32'h1000 for 2 cycles then busy=0 -> sleep_armed=1 on 2nd edge; domain enters DRAIN after 16 idle edges, OFF one cycle later.
REQ-035 Domain 0 OFF, wake_req[0] pulse 1 cycle -> powerup=1 next cycle, enable=ready=1 after 4 more edges; domain 1 unaffected.
REQ-036 busy[0]=1 on the 16th idle cycle -> no DRAIN, idle counter restarts from 0.
REQ-037 wake_req during DRAIN -> WARMUP directly, OFF never entered; reset asserted in WARMUP -> immediate ON outputs.
REQ-038 Build without PMU_RDSP_TRIGGER_EN, rdsp held 0 -> sleep_armed=1 from reset, power-down after 16 idle cycles.

Source files
------------

// File: rtl/pmu_pkg.sv
// Shared types for the power sequencer: per-domain state encoding and the
// enable/powerup/ready pattern each state drives.
package pmu_pkg;

  typedef enum logic [1:0] {
    ST_ON     = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_OFF    = 2'd2,
    ST_WARMUP = 2'd3
  } dom_state_t;

  typedef struct packed {
    logic enable;
    logic powerup;
    logic ready;
  } dom_out_t;

  localparam dom_out_t OUT_ON     = '{enable: 1'b1, powerup: 1'b1, ready: 1'b1};
  localparam dom_out_t OUT_DRAIN  = '{enable: 1'b0, powerup: 1'b1, ready: 1'b0};
  localparam dom_out_t OUT_OFF    = '{enable: 1'b0, powerup: 1'b0, ready: 1'b0};
  localparam dom_out_t OUT_WARMUP = '{enable: 1'b0, powerup: 1'b1, ready: 1'b0};

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic dom_out_t decode_state(input dom_state_t s);
    dom_out_t o;
    case (s)
      ST_ON:     o = OUT_ON;
      ST_DRAIN:  o = OUT_DRAIN;
      ST_OFF:    o = OUT_OFF;
      ST_WARMUP: o = OUT_WARMUP;
      default:   o = OUT_ON;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pmu_domain_fsm.sv
// One gated HF clock domain: ON -> DRAIN -> OFF -> WARMUP -> ON, with an idle
// run counter gating power-down and a fixed-length warmup on wake.
module pmu_domain_fsm
  import pmu_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES   = 16,
  parameter int unsigned WARMUP_CYCLES = 4
) (
  input  logic fast_clk,
  input  logic reset,
  input  logic wake_req,
  input  logic busy,
  input  logic sleep_armed,
  output logic clkhf_enable,
  output logic clkhf_powerup,
  output logic domain_ready
);

  localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES - 1);
  localparam int unsigned WARM_W = cnt_width(WARMUP_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

  dom_state_t        r_state, w_state_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [WARM_W-1:0] r_warm_cnt, w_warm_nxt;
  dom_out_t          r_out;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ON;
      r_idle_cnt <= '0;
      r_warm_cnt <= '0;
      r_out      <= OUT_ON;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_warm_cnt <= w_warm_nxt;
      r_out      <= decode_state(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_warm_nxt  = r_warm_cnt;
    unique case (r_state)
      ST_ON: begin
        w_warm_nxt = '0;
        // Any activity or a disarmed sequencer restarts the idle run.
        if (!busy && !wake_req && sleep_armed) begin
          if (r_idle_cnt == IDLE_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + IDLE_W'(1);
          end
        end else begin
          w_idle_nxt = '0;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = wake_req ? ST_WARMUP : ST_OFF;
        w_warm_nxt  = '0;
      end
      ST_OFF: begin
        if (wake_req) begin
          w_state_nxt = ST_WARMUP;
          w_warm_nxt  = '0;
        end
      end
      ST_WARMUP: begin
        if (r_warm_cnt == WARM_LAST) begin
          w_state_nxt = ST_ON;
          w_idle_nxt  = '0;
          w_warm_nxt  = '0;
        end else begin
          w_warm_nxt = r_warm_cnt + WARM_W'(1);
        end
      end
      default: w_state_nxt = ST_ON;
    endcase
  end

  assign clkhf_enable  = r_out.enable;
  assign clkhf_powerup = r_out.powerup;
  assign domain_ready  = r_out.ready;

endmodule

// File: rtl/power_sequencer.sv
// Power sequencer: NUM_DOMAINS independent HF clock domain FSMs sharing one
// sleep_armed qualifier. Define PMU_RDSP_TRIGGER_EN to arm sleep from rdsp hits;
// otherwise sleep is permanently armed and rdsp is ignored.
module power_sequencer
  import pmu_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS   = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IDLE_CYCLES   = 16,
  parameter int unsigned WARMUP_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] TRIGGER_VALUE = DATA_WIDTH'(32'h1000),
  parameter int unsigned TRIGGER_COUNT = 2
) (
  input  logic                   fast_clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  rdsp,
  input  logic [NUM_DOMAINS-1:0] wake_req,
  input  logic [NUM_DOMAINS-1:0] busy,
  output logic [NUM_DOMAINS-1:0] clkhf_enable,
  output logic [NUM_DOMAINS-1:0] clkhf_powerup,
  output logic [NUM_DOMAINS-1:0] domain_ready,
  output logic                   sleep_armed
);

`ifdef PMU_RDSP_TRIGGER_EN
  localparam int unsigned TRIG_W = cnt_width(TRIGGER_COUNT);
  localparam logic [TRIG_W-1:0] TRIG_SAT = TRIG_W'(TRIGGER_COUNT);

  logic [TRIG_W-1:0] r_trig_cnt, w_trig_nxt;
  logic              r_sleep_armed;

  // Saturating hit counter; once full, sleep stays armed until reset.
  always_comb begin
    w_trig_nxt = r_trig_cnt;
    if ((rdsp == TRIGGER_VALUE) && (r_trig_cnt != TRIG_SAT)) begin
      w_trig_nxt = r_trig_cnt + TRIG_W'(1);
    end
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_trig_cnt    <= '0;
      r_sleep_armed <= 1'b0;
    end else begin
      r_trig_cnt    <= w_trig_nxt;
      r_sleep_armed <= (w_trig_nxt == TRIG_SAT);
    end
  end

  assign sleep_armed = r_sleep_armed;
`else
  logic w_unused_trigger;

  assign w_unused_trigger = ^{rdsp, TRIGGER_VALUE, 32'(TRIGGER_COUNT)};
  assign sleep_armed      = 1'b1;
`endif

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    pmu_domain_fsm #(
      .IDLE_CYCLES   (IDLE_CYCLES),
      .WARMUP_CYCLES (WARMUP_CYCLES)
    ) u_fsm (
      .fast_clk      (fast_clk),
      .reset         (reset),
      .wake_req      (wake_req[g]),
      .busy          (busy[g]),
      .sleep_armed   (sleep_armed),
      .clkhf_enable  (clkhf_enable[g]),
      .clkhf_powerup (clkhf_powerup[g]),
      .domain_ready  (domain_ready[g])
    );
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer: directed scenarios followed by
// randomized busy/wake/rdsp traffic, checked against a phase-level model.
module tb_power_sequencer;

  localparam int unsigned ND   = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned IDLE = 16;
  localparam int unsigned WARM = 4;
  localparam int unsigned TC   = 2;
  localparam logic [DW-1:0] TV = 32'h1000;

  logic          fast_clk;
  logic          reset;
  logic [DW-1:0] rdsp;
  logic [ND-1:0] wake_req;
  logic [ND-1:0] busy;
  logic [ND-1:0] clkhf_enable;
  logic [ND-1:0] clkhf_powerup;
  logic [ND-1:0] domain_ready;
  logic          sleep_armed;

  int vectors     = 0;
  int miscompares = 0;

  power_sequencer #(
    .NUM_DOMAINS   (ND),
    .DATA_WIDTH    (DW),
    .IDLE_CYCLES   (IDLE),
    .WARMUP_CYCLES (WARM),
    .TRIGGER_VALUE (TV),
    .TRIGGER_COUNT (TC)
  ) dut (
    .fast_clk      (fast_clk),
    .reset         (reset),
    .rdsp          (rdsp),
    .wake_req      (wake_req),
    .busy          (busy),
    .clkhf_enable  (clkhf_enable),
    .clkhf_powerup (clkhf_powerup),
    .domain_ready  (domain_ready),
    .sleep_armed   (sleep_armed)
  );

  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  // Reference model: each domain is in a phase, with a count of consecutive
  // qualifying idle cycles and of warmup cycles already spent.
  typedef enum int {P_ON, P_DRAIN, P_OFF, P_WARM} phase_t;
  phase_t m_ph   [ND];
  int     m_run  [ND];
  int     m_warm [ND];
  int     m_hits;

  function automatic bit m_armed();
`ifdef PMU_RDSP_TRIGGER_EN
    return (m_hits >= int'(TC));
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_ph[d]   = P_ON;
      m_run[d]  = 0;
      m_warm[d] = 0;
    end
    m_hits = 0;
  endfunction

  function automatic void model_edge();
    bit armed_now;
    armed_now = m_armed();
    for (int d = 0; d < ND; d++) begin
      case (m_ph[d])
        P_ON: begin
          if (!busy[d] && !wake_req[d] && armed_now) begin
            m_run[d]++;
            if (m_run[d] >= int'(IDLE)) begin
              m_ph[d]  = P_DRAIN;
              m_run[d] = 0;
            end
          end else begin
            m_run[d] = 0;
          end
        end
        P_DRAIN: begin
          m_ph[d]   = wake_req[d] ? P_WARM : P_OFF;
          m_warm[d] = 0;
        end
        P_OFF: begin
          if (wake_req[d]) begin
            m_ph[d]   = P_WARM;
            m_warm[d] = 0;
          end
        end
        P_WARM: begin
          m_warm[d]++;
          if (m_warm[d] >= int'(WARM)) begin
            m_ph[d]  = P_ON;
            m_run[d] = 0;
          end
        end
        default: m_ph[d] = P_ON;
      endcase
    end
    if (rdsp == TV && m_hits < int'(TC)) m_hits++;
  endfunction

  task automatic check_all(input string tag);
    logic [ND-1:0] e_en;
    logic [ND-1:0] e_pu;
    logic          e_arm;
    for (int d = 0; d < ND; d++) begin
      e_en[d] = (m_ph[d] == P_ON);
      e_pu[d] = (m_ph[d] != P_OFF);
    end
    e_arm = m_armed();
    vectors++;
    assert (clkhf_enable === e_en) else begin
      miscompares++;
      $error("FAIL %s enable obs=%b exp=%b", tag, clkhf_enable, e_en);
    end
    vectors++;
    assert (clkhf_powerup === e_pu) else begin
      miscompares++;
      $error("FAIL %s powerup obs=%b exp=%b", tag, clkhf_powerup, e_pu);
    end
    vectors++;
    assert (domain_ready === e_en) else begin
      miscompares++;
      $error("FAIL %s ready obs=%b exp=%b", tag, domain_ready, e_en);
    end
    vectors++;
    assert (sleep_armed === e_arm) else begin
      miscompares++;
      $error("FAIL %s sleep_armed obs=%b exp=%b", tag, sleep_armed, e_arm);
    end
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare shortly after the edge.
  task automatic step(input string tag);
    @(posedge fast_clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int lat;
    reset    = 1'b1;
    rdsp     = '0;
    wake_req = '0;
    busy     = '0;
    model_reset();

    #12;
    check_all("in_reset");
    repeat (2) step("reset_hold");
    reset = 1'b0;
    busy  = '1;

    // Busy domains with non-trigger rdsp: everything stays ON.
    for (int i = 0; i < 20; i++) begin
      rdsp = $urandom();
      if (rdsp == TV) rdsp = '0;
      step("busy_hold");
    end
    rdsp = '0;

`ifdef PMU_RDSP_TRIGGER_EN
    busy = '0;
    repeat (10) step("disarmed_idle");
    expect_bit("disarmed_stay_on", domain_ready[0], 1'b1);
    rdsp = TV;
    step("trig_hit1");
    expect_bit("armed_after_one_hit", sleep_armed, 1'b0);
    step("trig_hit2");
    expect_bit("armed_after_two_hits", sleep_armed, 1'b1);
    rdsp = '0;
`endif

    // Idle run: DRAIN on the 16th qualifying edge, OFF one edge later.
    busy = '0;
    repeat (IDLE - 1) step("idle_run");
    expect_bit("still_on_before_16th", clkhf_enable[0], 1'b1);
    step("idle_16th");
    expect_bit("drain_enable", clkhf_enable[0], 1'b0);
    expect_bit("drain_powerup", clkhf_powerup[0], 1'b1);
    step("to_off");
    expect_bit("off_powerup", clkhf_powerup[1], 1'b0);

    // Busy is ignored while OFF.
    busy = '1;
    repeat (3) step("off_busy");
    busy = '0;

    // Wake latency from OFF; domain 1 remains OFF.
    wake_req[0] = 1'b1;
    step("wake_edge");
    wake_req[0] = 1'b0;
    expect_bit("wake_powerup", clkhf_powerup[0], 1'b1);
    lat = 0;
    while (!domain_ready[0] && lat < 20) begin
      step("warmup");
      lat++;
    end
    expect_int("wake_latency", lat, int'(WARM));
    expect_bit("dom1_still_off", clkhf_powerup[1], 1'b0);

    // Busy on the 16th idle cycle restarts the run.
    repeat (IDLE - 1) step("idle_a");
    busy[0] = 1'b1;
    step("busy_on_16th");
    busy[0] = 1'b0;
    expect_bit("no_drain_on_busy", domain_ready[0], 1'b1);
    repeat (IDLE - 1) step("idle_b");
    expect_bit("restart_still_on", domain_ready[0], 1'b1);
    step("idle_b_16th");
    expect_bit("restart_drain", clkhf_enable[0], 1'b0);

    // Wake in DRAIN goes straight to WARMUP, then async reset mid-warmup.
    wake_req[0] = 1'b1;
    step("drain_wake");
    wake_req[0] = 1'b0;
    expect_bit("drain_wake_powerup", clkhf_powerup[0], 1'b1);
    step("warm_mid");
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    step("reset_hold2");
    reset = 1'b0;

    // Randomized traffic in alternating quiet and noisy segments.
    for (int seg = 0; seg < 30; seg++) begin
      if (seg % 7 == 6) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rand_async_reset");
        step("rand_reset_hold");
        reset = 1'b0;
      end
      for (int i = 0; i < 100; i++) begin
        for (int d = 0; d < ND; d++) begin
          if (seg % 2 == 0) begin
            busy[d]     = ($urandom_range(0, 63) == 0);
            wake_req[d] = ($urandom_range(0, 31) == 0);
          end else begin
            busy[d]     = ($urandom_range(0, 3) == 0);
            wake_req[d] = ($urandom_range(0, 7) == 0);
          end
        end
        rdsp = ($urandom_range(0, 15) == 0) ? TV : DW'($urandom());
        step("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
